float_multiplier_pipelined: RTL and testbench

//  Parametrised, 3-stage pipelined floating-point multiplier with valid/ready handshake, RNE rounding and status flags.
//  One instance covers e4m3 (OCP FN) and bf16 (IEEE-style); sits in the datapath wherever a streaming FP multiply is needed.

---
 rtl/float_multiplier_pipelined.sv | 187 ++++++++++++++++++
 tb/tb_float_multiplier_pipelined.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/float_multiplier_pipelined.sv
// Three-stage pipelined floating-point multiplier (unpack / mantissa product / normalise-round-pack)
// with a valid/ready handshake, round-to-nearest-even and {invalid, overflow, underflow, inexact} flags.
module float_multiplier_pipelined #(
    parameter int EXP_WIDTH     = 4,
    parameter int MAN_WIDTH     = 3,
    parameter bit IEEE_SPECIALS = 1'b0,
    parameter bit SATURATE      = 1'b1,
    localparam int W            = 1 + EXP_WIDTH + MAN_WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic [3:0]   flags
);
    localparam int EW   = EXP_WIDTH + 2;
    localparam int PW   = 2 * MAN_WIDTH + 2;
    localparam int BIAS = 2 ** (EXP_WIDTH - 1) - 1;

    localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;
    localparam logic [MAN_WIDTH-1:0] MAN_ONES = '1;
    localparam logic [MAN_WIDTH-1:0] MAN_ZERO = '0;
    localparam logic [MAN_WIDTH-1:0] QNAN_MAN = IEEE_SPECIALS ? (MAN_WIDTH'(1) << (MAN_WIDTH - 1)) : MAN_ONES;
    localparam logic [MAN_WIDTH-1:0] MAX_MAN  = IEEE_SPECIALS ? MAN_ONES : MAN_ONES - MAN_WIDTH'(1);
    localparam logic [EXP_WIDTH-1:0] MAX_EXP  = IEEE_SPECIALS ? EXP_ONES - EXP_WIDTH'(1) : EXP_ONES;
    localparam logic signed [EW-1:0] BIAS_S   = EW'(BIAS);
    localparam logic signed [EW-1:0] TOP_EXP  = EW'(2 ** EXP_WIDTH - 1);

    logic en;

    logic [W-1:0]         opnd    [2];
    logic [EXP_WIDTH-1:0] op_exp  [2];
    logic [MAN_WIDTH:0]   op_sig  [2];
    logic [1:0]           op_zero;
    logic [1:0]           op_inf;
    logic [1:0]           op_nan;

    logic                 s1_nan_next, s1_inv_next, s1_inf_next, s1_zero_next;
    logic signed [EW-1:0] s1_exp_next;

    logic                 s1_valid_reg, s1_sign_reg, s1_nan_reg, s1_inv_reg, s1_inf_reg, s1_zero_reg;
    logic signed [EW-1:0] s1_exp_reg;
    logic [MAN_WIDTH:0]   s1_sig_a_reg, s1_sig_b_reg;

    logic                 s2_valid_reg, s2_sign_reg, s2_nan_reg, s2_inv_reg, s2_inf_reg, s2_zero_reg;
    logic signed [EW-1:0] s2_exp_reg;
    logic [PW-1:0]        s2_prod_reg;

    logic                 out_valid_reg;
    logic [W-1:0]         y_reg;
    logic [3:0]           flags_reg;

    logic                 prod_msb, guard, sticky, round_up, ovf, uf;
    logic [PW-2:0]        norm;
    logic [MAN_WIDTH-1:0] man_trunc, man_final;
    logic [MAN_WIDTH:0]   man_round;
    logic signed [EW-1:0] exp_final;
    logic [W-1:0]         y_next;
    logic [3:0]           flags_next;

    assign en       = !out_valid_reg || out_ready;
    assign in_ready = en;

    assign opnd[0] = a;
    assign opnd[1] = b;

    // Subnormal encodings (exp = 0) are deliberately treated as zero.
    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
        assign op_exp[gi]  = opnd[gi][W-2:MAN_WIDTH];
        assign op_sig[gi]  = {1'b1, opnd[gi][MAN_WIDTH-1:0]};
        assign op_zero[gi] = (op_exp[gi] == '0);
        if (IEEE_SPECIALS) begin : g_ieee
            assign op_inf[gi] = (op_exp[gi] == EXP_ONES) && (opnd[gi][MAN_WIDTH-1:0] == MAN_ZERO);
            assign op_nan[gi] = (op_exp[gi] == EXP_ONES) && (opnd[gi][MAN_WIDTH-1:0] != MAN_ZERO);
        end else begin : g_fn
            assign op_inf[gi] = 1'b0;
            assign op_nan[gi] = (opnd[gi][W-2:0] == '1);
        end
    end

    assign s1_inv_next  = (op_inf[0] && op_zero[1]) || (op_zero[0] && op_inf[1]);
    assign s1_nan_next  = (|op_nan) || s1_inv_next;
    assign s1_inf_next  = (|op_inf) && !s1_nan_next;
    assign s1_zero_next = (|op_zero) && !s1_nan_next && !s1_inf_next;
    assign s1_exp_next  = EW'(op_exp[0]) + EW'(op_exp[1]) - BIAS_S;

    always_comb begin
        prod_msb   = s2_prod_reg[PW-1];
        norm       = prod_msb ? s2_prod_reg[PW-2:0] : {s2_prod_reg[PW-3:0], 1'b0};
        man_trunc  = norm[PW-2 -: MAN_WIDTH];
        guard      = norm[MAN_WIDTH];
        sticky     = |norm[MAN_WIDTH-1:0];
        round_up   = guard && (sticky || man_trunc[0]);
        man_round  = {1'b0, man_trunc} + (MAN_WIDTH + 1)'(round_up);
        // A rounding carry leaves the stored mantissa at zero and bumps the exponent.
        man_final  = man_round[MAN_WIDTH-1:0];
        exp_final  = s2_exp_reg + EW'(prod_msb) + EW'(man_round[MAN_WIDTH]);
        uf         = exp_final[EW-1] || (exp_final == '0);
        if (IEEE_SPECIALS) begin
            ovf = (exp_final >= TOP_EXP);
        end else begin
            ovf = (exp_final > TOP_EXP) || ((exp_final == TOP_EXP) && (man_final > MAX_MAN));
        end

        y_next     = {s2_sign_reg, exp_final[EXP_WIDTH-1:0], man_final};
        flags_next = {3'b000, guard || sticky};
        if (s2_nan_reg) begin
            y_next     = {1'b0, EXP_ONES, QNAN_MAN};
            flags_next = {s2_inv_reg, 3'b000};
        end else if (s2_inf_reg) begin
            y_next     = {s2_sign_reg, EXP_ONES, MAN_ZERO};
            flags_next = 4'b0000;
        end else if (s2_zero_reg) begin
            y_next     = {s2_sign_reg, {(W-1){1'b0}}};
            flags_next = 4'b0000;
        end else if (ovf) begin
            flags_next = 4'b0101;
            if (SATURATE) begin
                y_next = {s2_sign_reg, MAX_EXP, MAX_MAN};
            end else if (IEEE_SPECIALS) begin
                y_next = {s2_sign_reg, EXP_ONES, MAN_ZERO};
            end else begin
                y_next = {1'b0, EXP_ONES, QNAN_MAN};
            end
        end else if (uf) begin
            y_next     = {s2_sign_reg, {(W-1){1'b0}}};
            flags_next = 4'b0011;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_reg  <= 1'b0;
            s1_sign_reg   <= 1'b0;
            s1_nan_reg    <= 1'b0;
            s1_inv_reg    <= 1'b0;
            s1_inf_reg    <= 1'b0;
            s1_zero_reg   <= 1'b0;
            s1_exp_reg    <= '0;
            s1_sig_a_reg  <= '0;
            s1_sig_b_reg  <= '0;
            s2_valid_reg  <= 1'b0;
            s2_sign_reg   <= 1'b0;
            s2_nan_reg    <= 1'b0;
            s2_inv_reg    <= 1'b0;
            s2_inf_reg    <= 1'b0;
            s2_zero_reg   <= 1'b0;
            s2_exp_reg    <= '0;
            s2_prod_reg   <= '0;
            out_valid_reg <= 1'b0;
            y_reg         <= '0;
            flags_reg     <= '0;
        end else if (en) begin
            s1_valid_reg  <= in_valid;
            s1_sign_reg   <= opnd[0][W-1] ^ opnd[1][W-1];
            s1_nan_reg    <= s1_nan_next;
            s1_inv_reg    <= s1_inv_next;
            s1_inf_reg    <= s1_inf_next;
            s1_zero_reg   <= s1_zero_next;
            s1_exp_reg    <= s1_exp_next;
            s1_sig_a_reg  <= op_sig[0];
            s1_sig_b_reg  <= op_sig[1];
            s2_valid_reg  <= s1_valid_reg;
            s2_sign_reg   <= s1_sign_reg;
            s2_nan_reg    <= s1_nan_reg;
            s2_inv_reg    <= s1_inv_reg;
            s2_inf_reg    <= s1_inf_reg;
            s2_zero_reg   <= s1_zero_reg;
            s2_exp_reg    <= s1_exp_reg;
            s2_prod_reg   <= PW'(s1_sig_a_reg) * PW'(s1_sig_b_reg);
            out_valid_reg <= s2_valid_reg;
            // Bubbles leave y and flags cleared so nothing stale is visible with out_valid low.
            y_reg         <= s2_valid_reg ? y_next : '0;
            flags_reg     <= s2_valid_reg ? flags_next : '0;
        end
    end

    assign out_valid = out_valid_reg;
    assign y         = y_reg;
    assign flags     = flags_reg;

endmodule

// File: tb/tb_float_multiplier_pipelined.sv
// Directed bench for float_multiplier_pipelined: an e4m3 (FN, saturating) and a bf16 (IEEE, non-saturating)
// instance share clock and reset; expected results are hand-computed constants.
module tb_float_multiplier_pipelined;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        e4_in_valid, e4_in_ready, e4_out_valid, e4_out_ready;
    logic [7:0]  e4_a, e4_b, e4_y;
    logic [3:0]  e4_flags;
    logic        bf_in_valid, bf_in_ready, bf_out_valid, bf_out_ready;
    logic [15:0] bf_a, bf_b, bf_y;
    logic [3:0]  bf_flags;

    int checks = 0;
    int errors = 0;
    int issue;
    logic accepted;

    logic [15:0] bp_a [5] = '{16'hBF40, 16'hBF80, 16'h4348, 16'h7F80, 16'h7F80};
    logic [15:0] bp_b [5] = '{16'h3FE0, 16'hBF80, 16'h3A83, 16'h0000, 16'hBF80};
    logic [15:0] bp_y [5] = '{16'hBFA8, 16'h3F80, 16'h3E4D, 16'h7FC0, 16'hFF80};
    logic [3:0]  bp_f [5] = '{4'h0, 4'h0, 4'h1, 4'h8, 4'h0};

    float_multiplier_pipelined #(
        .EXP_WIDTH(4), .MAN_WIDTH(3), .IEEE_SPECIALS(1'b0), .SATURATE(1'b1)
    ) u_e4m3 (
        .clock(clk), .reset(reset),
        .in_valid(e4_in_valid), .in_ready(e4_in_ready), .a(e4_a), .b(e4_b),
        .out_valid(e4_out_valid), .out_ready(e4_out_ready), .y(e4_y), .flags(e4_flags)
    );

    float_multiplier_pipelined #(
        .EXP_WIDTH(8), .MAN_WIDTH(7), .IEEE_SPECIALS(1'b1), .SATURATE(1'b0)
    ) u_bf16 (
        .clock(clk), .reset(reset),
        .in_valid(bf_in_valid), .in_ready(bf_in_ready), .a(bf_a), .b(bf_b),
        .out_valid(bf_out_valid), .out_ready(bf_out_ready), .y(bf_y), .flags(bf_flags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One isolated multiply: accept, confirm nothing after two edges, result after the third.
    task automatic run_op(input bit is_bf, input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] yv, input logic [3:0] fv, input string tag);
        @(negedge clk);
        if (is_bf) begin
            bf_a = av; bf_b = bv; bf_in_valid = 1'b1;
            check({tag, "_in_ready"}, bf_in_ready, 1);
        end else begin
            e4_a = av[7:0]; e4_b = bv[7:0]; e4_in_valid = 1'b1;
            check({tag, "_in_ready"}, e4_in_ready, 1);
        end
        @(posedge clk); #1;
        e4_in_valid = 1'b0;
        bf_in_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, "_early_valid"}, is_bf ? bf_out_valid : e4_out_valid, 0);
        check({tag, "_early_flags"}, is_bf ? bf_flags : e4_flags, 0);
        @(posedge clk); #1;
        check({tag, "_valid"}, is_bf ? bf_out_valid : e4_out_valid, 1);
        check({tag, "_y"}, is_bf ? bf_y : {8'h00, e4_y}, yv);
        check({tag, "_flags"}, is_bf ? bf_flags : e4_flags, fv);
        $display("txn %s: %h * %h -> y=%h flags=%b", tag, av, bv,
                 is_bf ? bf_y : {8'h00, e4_y}, is_bf ? bf_flags : e4_flags);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        e4_in_valid = 1'b0; e4_a = '0; e4_b = '0; e4_out_ready = 1'b1;
        bf_in_valid = 1'b0; bf_a = '0; bf_b = '0; bf_out_ready = 1'b1;
        #2;
        check("rst_e4_valid", e4_out_valid, 0);
        check("rst_e4_y", e4_y, 0);
        check("rst_e4_flags", e4_flags, 0);
        check("rst_e4_in_ready", e4_in_ready, 1);
        check("rst_bf_valid", bf_out_valid, 0);
        check("rst_bf_y", bf_y, 0);
        @(negedge clk);
        reset = 1'b1;

        run_op(1'b0, 16'h40, 16'h40, 16'h48, 4'h0, "e4_2x2");
        run_op(1'b0, 16'hAC, 16'hC0, 16'h34, 4'h0, "e4_neg_neg");
        run_op(1'b0, 16'h00, 16'h00, 16'h00, 4'h0, "e4_zero");
        run_op(1'b0, 16'h39, 16'h3C, 16'h3E, 4'h1, "e4_tie_up");
        run_op(1'b0, 16'h3A, 16'h3A, 16'h3C, 4'h1, "e4_tie_even");
        run_op(1'b0, 16'h7E, 16'h48, 16'h7E, 4'h5, "e4_ovf_sat");
        run_op(1'b0, 16'h77, 16'h40, 16'h7E, 4'h5, "e4_ovf_top_man");
        run_op(1'b0, 16'h76, 16'h40, 16'h7E, 4'h0, "e4_max_exact");
        run_op(1'b0, 16'h7F, 16'h38, 16'h7F, 4'h0, "e4_nan");
        run_op(1'b0, 16'h08, 16'h08, 16'h00, 4'h3, "e4_uflow");
        run_op(1'b0, 16'h88, 16'h08, 16'h80, 4'h3, "e4_uflow_neg");

        for (int i = 0; i < 5; i++) begin
            run_op(1'b1, bp_a[i], bp_b[i], bp_y[i], bp_f[i], $sformatf("bf_dir%0d", i));
        end
        run_op(1'b1, 16'h7F00, 16'h4000, 16'h7F80, 4'h5, "bf_ovf_inf");
        run_op(1'b1, 16'h7F00, 16'h3F80, 16'h7F00, 4'h0, "bf_max_exp");

        // Backpressure: fill three stages with out_ready low, hold six cycles, then drain.
        repeat (2) @(posedge clk);
        #1;
        bf_out_ready = 1'b0;
        issue = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bf_a = bp_a[issue]; bf_b = bp_b[issue]; bf_in_valid = 1'b1;
            check("bp_fill_ready", bf_in_ready, 1);
            @(posedge clk);
            issue++;
        end
        @(negedge clk);
        bf_a = bp_a[3]; bf_b = bp_b[3];
        for (int c = 0; c < 6; c++) begin
            check("bp_stall_in_ready", bf_in_ready, 0);
            check("bp_stall_valid", bf_out_valid, 1);
            check("bp_stall_y", bf_y, bp_y[0]);
            $display("txn bp_stall cycle %0d: y=%h in_ready=%b", c, bf_y, bf_in_ready);
            @(negedge clk);
        end
        bf_out_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("bp_drain_valid", bf_out_valid, 1);
            check("bp_drain_y", bf_y, bp_y[k]);
            check("bp_drain_flags", bf_flags, bp_f[k]);
            $display("txn bp_drain %0d: y=%h flags=%b", k, bf_y, bf_flags);
            accepted = bf_in_valid && bf_in_ready;
            @(posedge clk);
            if (accepted) issue++;
            @(negedge clk);
            if (issue < 5) begin
                bf_a = bp_a[issue]; bf_b = bp_b[issue];
            end else begin
                bf_in_valid = 1'b0;
            end
        end
        check("bp_issued", issue, 5);
        check("bp_after_drain_valid", bf_out_valid, 0);

        // Reset mid-flight: bf result parked at the output, two e4m3 ops still inside.
        repeat (2) @(posedge clk);
        @(negedge clk);
        bf_out_ready = 1'b0;
        bf_a = 16'h7F80; bf_b = 16'h0000; bf_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bf_in_valid = 1'b0;
        e4_a = 8'h40; e4_b = 8'h40; e4_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        e4_a = 8'h39; e4_b = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        e4_in_valid = 1'b0;
        check("rst_pre_bf_valid", bf_out_valid, 1);
        check("rst_pre_bf_flags", bf_flags, 4'h8);
        check("rst_pre_e4_valid", e4_out_valid, 0);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_bf_valid", bf_out_valid, 0);
        check("rst_mid_bf_y", bf_y, 0);
        check("rst_mid_bf_flags", bf_flags, 0);
        check("rst_mid_bf_in_ready", bf_in_ready, 1);
        check("rst_mid_e4_valid", e4_out_valid, 0);
        $display("txn reset_mid_flight: bf_out_valid=%b e4_out_valid=%b", bf_out_valid, e4_out_valid);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("rst_post_e4_valid", e4_out_valid, 0);
            check("rst_post_bf_valid", bf_out_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
